// File: rtl/csr_access_if.sv
// Bundle of the execute-stage request channel, the CSR register-file port and the
// writeback response channel of csr_access_unit.
//   slave  : the access unit (accepts requests, drives register-file address/write data,
//            produces responses)
//   master : the surrounding pipeline / register file / testbench
// Signals:
//   flush                                        abandon in-flight operation
//   req_valid/req_ready, req_op, req_src,
//   req_src_zero, req_addr, req_rd               decoded Zicsr request
//   csr_addr_r/csr_data_r                        combinational read port
//   csr_addr_w/csr_data_w/csr_we                 registered write port
//   rsp_valid/rsp_ready, rsp_rd, rsp_data,
//   rsp_illegal                                  rd writeback response
interface csr_access_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_src;
  logic            req_src_zero;
  logic [11:0]     req_addr;
  logic [4:0]      req_rd;

  logic [11:0]     csr_addr_r;
  logic [XLEN-1:0] csr_data_r;
  logic [11:0]     csr_addr_w;
  logic [XLEN-1:0] csr_data_w;
  logic            csr_we;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [4:0]      rsp_rd;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_illegal;

  modport slave (
    input  flush,
    input  req_valid, req_op, req_src, req_src_zero, req_addr, req_rd,
    output req_ready,
    output csr_addr_r,
    input  csr_data_r,
    output csr_addr_w, csr_data_w, csr_we,
    output rsp_valid, rsp_rd, rsp_data, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output flush,
    output req_valid, req_op, req_src, req_src_zero, req_addr, req_rd,
    input  req_ready,
    input  csr_addr_r,
    output csr_data_r,
    input  csr_addr_w, csr_data_w, csr_we,
    input  rsp_valid, rsp_rd, rsp_data, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write engine (CSRRW/CSRRS/CSRRC and their immediate forms).
// One request at a time: latch the decoded request, read the old CSR value through the
// register file's combinational read port, optionally write the new value through its
// registered write port, then hold the old value as the rd writeback response.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, priority over everything else
//   bus  - csr_access_if.slave: request channel, register-file ports, response channel
//          and flush
module csr_access_unit #(
  parameter int unsigned XLEN        = 32,
  parameter bit          RO_CHECK_EN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  csr_access_if.slave bus
);

  localparam logic [1:0] OpIll = 2'b00;
  localparam logic [1:0] OpRw  = 2'b01;
  localparam logic [1:0] OpRs  = 2'b10;
  localparam logic [1:0] OpRc  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] src_q, src_d;
  logic            src_zero_q, src_zero_d;
  logic [11:0]     addr_q, addr_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] old_q, old_d;

  logic req_ready;
  logic accept;
  logic wen;
  logic illegal;

  // A flush or reset in progress must not let a new request slip in.
  assign req_ready = (state_q == StIdle) && !rst && !bus.flush;
  assign accept    = bus.req_valid && req_ready;

  // RS/RC with x0 / uimm=0 are pure reads: they never write and so never trip the
  // read-only check.
  assign wen     = (op_q == OpRw) || !src_zero_q;
  assign illegal = (op_q == OpIll) || (RO_CHECK_EN && (addr_q[11:10] == 2'b11) && wen);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    src_zero_d = src_zero_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    old_d      = old_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d       = bus.req_op;
          src_d      = bus.req_src;
          src_zero_d = bus.req_src_zero;
          addr_d     = bus.req_addr;
          rd_d       = bus.req_rd;
          state_d    = StRead;
        end
      end
      StRead: begin
        old_d   = bus.csr_data_r;
        state_d = (wen && !illegal) ? StWrite : StResp;
      end
      StWrite: begin
        state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Flush abandons whatever is in flight, including an unconsumed response.
    if (bus.flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OpIll;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      addr_q     <= '0;
      rd_q       <= '0;
      old_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_q      <= src_d;
      src_zero_q <= src_zero_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      old_q      <= old_d;
    end
  end

  // Outputs: everything idles at zero outside the state that owns it.
  always_comb begin
    bus.req_ready   = req_ready;
    bus.csr_addr_r  = '0;
    bus.csr_addr_w  = '0;
    bus.csr_data_w  = '0;
    bus.csr_we      = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_rd      = '0;
    bus.rsp_data    = '0;
    bus.rsp_illegal = 1'b0;

    unique case (state_q)
      StRead: begin
        bus.csr_addr_r = addr_q;
      end
      StWrite: begin
        bus.csr_addr_w = addr_q;
        // Gated combinationally so a same-cycle flush or reset suppresses the write.
        bus.csr_we     = !bus.flush && !rst;
        case (op_q)
          OpRw:    bus.csr_data_w = src_q;
          OpRs:    bus.csr_data_w = old_q | src_q;
          OpRc:    bus.csr_data_w = old_q & ~src_q;
          default: bus.csr_data_w = '0;
        endcase
      end
      StResp: begin
        bus.rsp_valid   = !bus.flush && !rst;
        bus.rsp_rd      = rd_q;
        bus.rsp_data    = illegal ? '0 : old_q;
        bus.rsp_illegal = illegal;
      end
      default: begin
      end
    endcase
  end

endmodule
